// File: rtl/spatz_boot_responder.sv
// Boot register window for the Spatz cluster: stores the entry point and
// fires a delayed, one-cycle per-core debug wake-up pulse.
module spatz_boot_responder #(
    parameter int unsigned          NumCores  = 4,
    parameter int unsigned          AddrWidth = 48,
    parameter int unsigned          DataWidth = 64,
    parameter logic [AddrWidth-1:0] BaseAddr  = '0,
    parameter int unsigned          WakeDelay = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   q_valid_i,
    output logic                   q_ready_o,
    input  logic [AddrWidth-1:0]   q_addr_i,
    input  logic                   q_write_i,
    input  logic [DataWidth-1:0]   q_data_i,
    input  logic [DataWidth/8-1:0] q_strb_i,
    output logic                   p_valid_o,
    input  logic                   p_ready_i,
    output logic [DataWidth-1:0]   p_data_o,
    output logic                   p_error_o,
    output logic [31:0]            boot_addr_o,
    output logic [NumCores-1:0]    debug_req_o,
    output logic                   busy_o
);

    localparam int unsigned CntW      = $clog2(WakeDelay + 1);
    localparam logic [11:0] OffBoot   = 12'h000;
    localparam logic [11:0] OffWake   = 12'h008;
    localparam logic [11:0] OffStatus = 12'h010;

    // Handshake: a request transfers on a rising edge where q_valid_i and
    // q_ready_o are both high; a response transfers on an edge where p_valid_o
    // and p_ready_i are both high. Once raised, p_valid_o and the response
    // fields hold until that transfer.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic [DataWidth-1:0] resp_data_q, resp_data_d;
    logic                 resp_error_q, resp_error_d;
    logic [31:0]          boot_addr_q, boot_merged;
    logic [NumCores-1:0]  mask_q, debug_req_q;
    logic [CntW-1:0]      cnt_q;
    logic                 busy_q, booted_q;
    logic [7:0]           pulse_cnt_q;

    logic        accept, in_window, boot_we, wake_load, pulse_fire;
    logic [11:0] offset;
    logic [15:0] status_word;
    logic        unused_bits;

    assign accept      = q_valid_i & q_ready_o;
    assign in_window   = (q_addr_i[AddrWidth-1:12] == BaseAddr[AddrWidth-1:12]);
    assign offset      = q_addr_i[11:0];
    assign status_word = {pulse_cnt_q, 6'b0, busy_q, booted_q};
    assign pulse_fire  = busy_q && (cnt_q == CntW'(1));
    assign unused_bits = ^{q_data_i[DataWidth-1:32], q_strb_i[DataWidth/8-1:4]};

    // ---------------- Response FSM ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RESP;
            ST_RESP: if (p_ready_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        q_ready_o = (state_q == ST_IDLE) && !rst_i;
        p_valid_o = (state_q == ST_RESP);
    end

    // ---------------- Request decode ----------------
    always_comb begin
        resp_data_d  = '0;
        resp_error_d = 1'b0;
        boot_we      = 1'b0;
        wake_load    = 1'b0;
        if (!in_window) begin
            resp_error_d = 1'b1;
        end else begin
            case (offset)
                OffBoot: begin
                    if (q_write_i) boot_we = 1'b1;
                    else           resp_data_d = {{(DataWidth-32){1'b0}}, boot_addr_q};
                end
                OffWake: begin
                    // A second wake while one is pending is refused, not queued.
                    if (q_write_i) begin
                        if (busy_q) resp_error_d = 1'b1;
                        else        wake_load = 1'b1;
                    end
                end
                OffStatus: begin
                    if (!q_write_i) resp_data_d = {{(DataWidth-16){1'b0}}, status_word};
                end
                default: resp_error_d = 1'b1;
            endcase
        end
    end

    always_comb begin
        boot_merged = boot_addr_q;
        for (int i = 0; i < 4; i++) begin
            if (q_strb_i[i]) boot_merged[8*i +: 8] = q_data_i[8*i +: 8];
        end
    end

    // ---------------- Response and boot registers ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_data_q  <= '0;
            resp_error_q <= 1'b0;
            boot_addr_q  <= '0;
        end else if (accept) begin
            resp_data_q  <= resp_data_d;
            resp_error_q <= resp_error_d;
            if (boot_we) boot_addr_q <= boot_merged;
        end
    end

    // ---------------- Wake engine ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            mask_q      <= '0;
            debug_req_q <= '0;
            booted_q    <= 1'b0;
            pulse_cnt_q <= '0;
        end else begin
            debug_req_q <= '0;
            if (accept && wake_load) begin
                busy_q <= 1'b1;
                cnt_q  <= CntW'(WakeDelay);
                mask_q <= q_data_i[NumCores-1:0];
            end else if (busy_q) begin
                cnt_q <= cnt_q - CntW'(1);
                // Counter lands on zero at this edge: pulse in the next cycle.
                if (pulse_fire) begin
                    busy_q      <= 1'b0;
                    debug_req_q <= mask_q;
                    booted_q    <= 1'b1;
                    if (pulse_cnt_q != 8'hFF) pulse_cnt_q <= pulse_cnt_q + 8'd1;
                end
            end
        end
    end

    assign p_data_o    = resp_data_q;
    assign p_error_o   = resp_error_q;
    assign boot_addr_o = boot_addr_q;
    assign debug_req_o = debug_req_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_spatz_boot_responder.sv
// Directed bench for spatz_boot_responder: register vectors from a table,
// then hand-written wake, collision, backpressure and reset sequences.
module tb_spatz_boot_responder;

    localparam int NumCores  = 4;
    localparam int WakeDelay = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                q_valid, q_ready, q_write;
    logic [47:0]         q_addr;
    logic [63:0]         q_data;
    logic [7:0]          q_strb;
    logic                p_valid, p_ready, p_error;
    logic [63:0]         p_data;
    logic [31:0]         boot_addr;
    logic [NumCores-1:0] debug_req;
    logic                busy;

    spatz_boot_responder #(
        .NumCores (NumCores),
        .AddrWidth(48),
        .DataWidth(64),
        .BaseAddr (48'h0),
        .WakeDelay(WakeDelay)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .q_valid_i  (q_valid),
        .q_ready_o  (q_ready),
        .q_addr_i   (q_addr),
        .q_write_i  (q_write),
        .q_data_i   (q_data),
        .q_strb_i   (q_strb),
        .p_valid_o  (p_valid),
        .p_ready_i  (p_ready),
        .p_data_o   (p_data),
        .p_error_o  (p_error),
        .boot_addr_o(boot_addr),
        .debug_req_o(debug_req),
        .busy_o     (busy)
    );

    // ---------------- Clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- Scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- Driver tasks ----------------
    int   acc_cyc;
    logic busy_n1;

    // Called just after a rising edge; returns two cycles after acceptance.
    task automatic txn(input logic w, input logic [47:0] a, input logic [63:0] d,
                       input logic [7:0] s, output logic [63:0] rd, output logic er);
        int t;
        q_valid = 1'b1; q_write = w; q_addr = a; q_data = d; q_strb = s;
        p_ready = 1'b1;
        t = 0;
        while (!q_ready && t < 20) begin
            @(posedge clk); #1; t++;
        end
        check("q_ready_wait", q_ready, 1);
        @(posedge clk); #1;
        q_valid = 1'b0;
        acc_cyc = cyc;
        busy_n1 = busy;
        check("p_valid_after_accept", p_valid, 1);
        rd = p_data;
        er = p_error;
        @(posedge clk); #1;
    endtask

    // a = cycle index of the cycle right after the accepting edge.
    task automatic wait_pulse(input int a, input logic [NumCores-1:0] m);
        while (cyc < a + WakeDelay) begin
            check($sformatf("busy_c%0d", cyc - a), busy, 1);
            check($sformatf("no_pulse_c%0d", cyc - a), debug_req, 0);
            @(posedge clk); #1;
        end
        check("pulse_mask", debug_req, m);
        check("busy_clear_at_pulse", busy, 0);
        @(posedge clk); #1;
        check("pulse_one_cycle", debug_req, 0);
    endtask

    typedef struct {
        logic        w;
        logic [47:0] a;
        logic [63:0] d;
        logic [7:0]  s;
        logic [63:0] ed;
        logic        ee;
        logic [31:0] eb;
    } vec_t;

    vec_t        vecs[14];
    logic [63:0] rd;
    logic        er;

    initial begin
        vecs[0]  = '{1'b1, 48'h000, 64'h0000_0000_8000_0000, 8'hFF, 64'h0, 1'b0, 32'h8000_0000};
        vecs[1]  = '{1'b1, 48'h000, 64'h0000_0000_0000_1234, 8'h01, 64'h0, 1'b0, 32'h8000_0034};
        vecs[2]  = '{1'b0, 48'h000, 64'h0, 8'h00, 64'h0000_0000_8000_0034, 1'b0, 32'h8000_0034};
        vecs[3]  = '{1'b1, 48'h000, 64'hFFFF_FFFF_AABB_CCDD, 8'hF0, 64'h0, 1'b0, 32'h8000_0034};
        vecs[4]  = '{1'b1, 48'h000, 64'h0000_0000_1100_0000, 8'h08, 64'h0, 1'b0, 32'h1100_0034};
        vecs[5]  = '{1'b0, 48'h020, 64'h0, 8'h00, 64'h0, 1'b1, 32'h1100_0034};
        vecs[6]  = '{1'b1, 48'h020, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0, 1'b1, 32'h1100_0034};
        vecs[7]  = '{1'b0, 48'h010, 64'h0, 8'h00, 64'h0, 1'b0, 32'h1100_0034};
        vecs[8]  = '{1'b0, 48'h008, 64'h0, 8'h00, 64'h0, 1'b0, 32'h1100_0034};
        vecs[9]  = '{1'b1, 48'h010, 64'hFFFF, 8'hFF, 64'h0, 1'b0, 32'h1100_0034};
        vecs[10] = '{1'b0, 48'h010, 64'h0, 8'h00, 64'h0, 1'b0, 32'h1100_0034};
        vecs[11] = '{1'b1, 48'h1000, 64'h0000_0000_DEAD_BEEF, 8'hFF, 64'h0, 1'b1, 32'h1100_0034};
        vecs[12] = '{1'b0, 48'h004, 64'h0, 8'h00, 64'h0, 1'b1, 32'h1100_0034};
        vecs[13] = '{1'b0, 48'hFFFF_FFFF_F000, 64'h0, 8'h00, 64'h0, 1'b1, 32'h1100_0034};

        rst = 1'b1; q_valid = 1'b0; q_write = 1'b0; q_addr = '0; q_data = '0;
        q_strb = '0; p_ready = 1'b0;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_q_ready", q_ready, 0);
        check("rst_p_valid", p_valid, 0);
        check("rst_p_data", p_data, 0);
        check("rst_p_error", p_error, 0);
        check("rst_boot_addr", boot_addr, 0);
        check("rst_debug_req", debug_req, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        #1;
        check("q_ready_after_release", q_ready, 1);

        // Register vectors
        for (int i = 0; i < 14; i++) begin
            exp_q.push_back(vecs[i].ed);
            txn(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].s, rd, er);
            check($sformatf("vec%0d_data", i), rd, exp_q.pop_front());
            check($sformatf("vec%0d_error", i), er, vecs[i].ee);
            check($sformatf("vec%0d_boot", i), boot_addr, vecs[i].eb);
        end

        // Basic wake
        txn(1'b1, 48'h008, 64'hF, 8'hFF, rd, er);
        check("wake_err", er, 0);
        check("wake_busy_n1", busy_n1, 1);
        wait_pulse(acc_cyc, 4'hF);
        txn(1'b0, 48'h010, 64'h0, 8'h00, rd, er);
        check("status_after_wake", rd, 64'h0101);

        // Collision, status while busy, boot write while busy
        begin
            int a0;
            txn(1'b1, 48'h008, 64'hF, 8'hFF, rd, er);
            a0 = acc_cyc;
            check("wake2_err", er, 0);
            txn(1'b1, 48'h008, 64'h3, 8'hFF, rd, er);
            check("collision_err", er, 1);
            check("collision_data", rd, 0);
            txn(1'b0, 48'h010, 64'h0, 8'h00, rd, er);
            check("status_busy", rd, 64'h0103);
            txn(1'b1, 48'h000, 64'h0000_0000_2000_0000, 8'h0F, rd, er);
            check("boot_while_busy", boot_addr, 32'h2000_0000);
            wait_pulse(a0, 4'hF);
        end

        // Zero-mask wake
        txn(1'b1, 48'h008, 64'h0, 8'hFF, rd, er);
        wait_pulse(acc_cyc, 4'h0);
        txn(1'b0, 48'h010, 64'h0, 8'h00, rd, er);
        check("status_zero_mask", rd, 64'h0301);

        // Backpressure
        p_ready = 1'b0;
        q_valid = 1'b1; q_write = 1'b0; q_addr = 48'h000; q_strb = '0;
        check("bp_q_ready_idle", q_ready, 1);
        @(posedge clk); #1;
        q_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_valid_%0d", i), p_valid, 1);
            check($sformatf("bp_data_%0d", i), p_data, 64'h2000_0000);
            check($sformatf("bp_q_ready_%0d", i), q_ready, 0);
            @(posedge clk); #1;
        end
        p_ready = 1'b1;
        check("bp_valid_held", p_valid, 1);
        @(posedge clk); #1;
        check("bp_valid_drop", p_valid, 0);
        check("bp_q_ready_back", q_ready, 1);

        // Reset mid-wake
        txn(1'b1, 48'h008, 64'hF, 8'hFF, rd, er);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_busy", busy, 0);
        check("midrst_boot", boot_addr, 0);
        check("midrst_p_valid", p_valid, 0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check($sformatf("midrst_no_pulse_%0d", i), debug_req, 0);
            check($sformatf("midrst_idle_%0d", i), busy, 0);
            @(posedge clk); #1;
        end
        txn(1'b0, 48'h010, 64'h0, 8'h00, rd, er);
        check("midrst_status", rd, 0);
        check("midrst_status_err", er, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spatz_boot_responder.md
# spatz_boot_responder

Synthesizable reqrsp responder that terminates the host-side boot handshake for the Spatz cluster. It accepts single-beat reqrsp reads and writes for a small boot register window and latches the cluster entry point. After a programmable delay it fires a one-cycle per-core debug wake-up pulse. It is the receiving end of the boot sequence a host or harness drives: entry-point store, then core wake-up.

## Interface
Parameters:
- NumCores, 4: number of cores; width of the wake mask and of `debug_req_o`.
- AddrWidth, 48: reqrsp address width.
- DataWidth, 64: reqrsp data width; fixed at 64, other values are unsupported.
- BaseAddr, 48'h0: base of the 4 KiB register window; must be 4 KiB aligned.
- WakeDelay, 16: cycles from an accepted WAKE write to the pulse; must be ≥1; counter width is `$clog2(WakeDelay+1)`.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- q_valid_i  in  1  request valid.
- q_ready_o  out  1  request ready.
- q_addr_i  in  AddrWidth  byte address.
- q_write_i  in  1  1 = write, 0 = read.
- q_data_i  in  64  write data.
- q_strb_i  in  8  byte strobes.
- p_valid_o  out  1  response valid.
- p_ready_i  in  1  response ready.
- p_data_o  out  64  read data; 0 for writes and errors.
- p_error_o  out  1  error response.
- boot_addr_o  out  32  latched entry point.
- debug_req_o  out  NumCores  wake pulse.
- busy_o  out  1  a wake is pending.

## Operation
Register map (offset = `addr - BaseAddr`):
- 0x000 BOOT_CONTROL, RW: bits [31:0] hold the entry point. Writes are byte-merged using `q_strb_i[3:0]`; strobes [7:4] are ignored. Reads return `{32'b0, boot_addr}`.
- 0x008 WAKE, WO: a write loads `mask = q_data_i[NumCores-1:0]` and arms the delay counter to WakeDelay. Reads return 0 with no error.
- 0x010 STATUS, RO: bit 0 = booted (set by the first wake pulse, cleared only by reset); bit 1 = busy; bits [15:8] = wake pulse count, saturating at 255. Writes are ignored with no error.
- Any other address, including any address outside the 4 KiB window: `p_error_o=1`, `p_data_o=0`, no state change.

Response FSM has two states:
- IDLE: `q_ready_o=1`. On `q_valid_i`, decode the request, apply any side effect in the same edge, register the response, and go to RESP.
- RESP: `q_ready_o=0`, `p_valid_o=1`, response fields held stable. On `p_ready_i`, return to IDLE.

Wake engine:
- When busy, the counter decrements once per cycle.
- On the cycle the counter reaches 0: `debug_req_o=mask` for exactly one cycle, busy clears, booted sets, and the pulse count increments.
- A WAKE write while busy is answered with `p_error_o=1` and is dropped; the pending wake is unaffected.
- A WAKE write with mask=0 still runs the delay but produces an all-zero pulse. The pulse count still increments.
- A BOOT_CONTROL write while busy is allowed; `boot_addr_o` updates immediately.

## Timing
- Reset values: `q_ready_o=0` during reset and 1 in the first cycle after reset deasserts. `p_valid_o`, `p_data_o`, `p_error_o`, `boot_addr_o`, `debug_req_o` and `busy_o` are all 0. Counter, mask, booted and pulse count are 0.
- Handshake:
  - Request accepted at edge N (`q_valid_i & q_ready_o`) → `p_valid_o=1` from cycle N+1.
  - Throughput is one transaction per 2 cycles when `p_ready_i` is held high.
  - The responder never drops `p_valid_o` before `p_ready_i`.
  - The initiator may raise `q_valid_i` at any time and must hold it until ready.
- `boot_addr_o` changes in the cycle after the accepting edge.
- A WAKE write accepted at edge N: `busy_o=1` from N+1, and `debug_req_o` is high in cycle N+WakeDelay+1 only.
- Reset asserted mid-transaction or mid-wake: everything returns to reset values at the next edge. No pending response or pulse survives.

## Test plan
- Reset: assert `rst_i` for 3 cycles → all outputs 0; `q_ready_o=1` on the first cycle after release.
- Boot write: write 0x000 with data 0x8000_0000 and strb 0xFF → `p_valid_o` the next cycle with `p_error_o=0`; `boot_addr_o=0x8000_0000`. Then write 0x000 with data 0x0000_1234 and strb 0x01 → `boot_addr_o=0x8000_0034`. A read of 0x000 returns 0x0000_0000_8000_0034.
- Wake: write 0x008 with data 0xF, WakeDelay=16, accepted at edge N → `busy_o` high for cycles N+1..N+16; `debug_req_o=4'hF` in cycle N+17 only. A STATUS read afterwards returns 0x0101.
- Wake collision: a second WAKE write while busy → `p_error_o=1`; the original pulse timing and mask are unchanged.
- Backpressure and errors:
  - Hold `p_ready_i=0` for 5 cycles → `p_valid_o` stays high, data stays stable and `q_ready_o=0` throughout.
  - Access to 0x020 → `p_error_o=1`, `p_data_o=0`.
- Reset mid-wake: assert `rst_i` 3 cycles after a WAKE write → no pulse, `busy_o=0`, and a STATUS read returns 0.
